// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: picks one of the ALU / load results per cycle for the
// single register-file write port, with starvation protection for the ALU.
//
// state   | meaning
// MEM_PRI | load wins when both paths are valid (reset state)
// ALU_PRI | ALU wins when both are valid; returns to MEM_PRI after the ALU is granted
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            stall,
  output logic            reg_write,
  output logic [4:0]      write_rd,
  output logic [XLEN-1:0] write_data,
  output logic            wb_src
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {MEM_PRI = 1'b0, ALU_PRI = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_starve, w_starve_nxt;
  logic          w_alu_gnt, w_mem_gnt;

  // Grants depend only on valids, stall and state; never on rd or data.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    if (rst_n && !stall) begin
      if (alu_valid && mem_valid) begin
        if (r_state == ALU_PRI) w_alu_gnt = 1'b1;
        else                    w_mem_gnt = 1'b1;
      end else begin
        w_alu_gnt = alu_valid;
        w_mem_gnt = mem_valid;
      end
    end
  end

  assign alu_ready = w_alu_gnt;
  assign mem_ready = w_mem_gnt;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    if (!stall) begin
      if (w_alu_gnt || !alu_valid)
        w_starve_nxt = '0;
      else if (w_mem_gnt && (r_starve != LIMIT))
        w_starve_nxt = r_starve + CW'(1);
      case (r_state)
        MEM_PRI: if (w_starve_nxt == LIMIT) w_state_nxt = ALU_PRI;
        ALU_PRI: if (w_alu_gnt)             w_state_nxt = MEM_PRI;
        default: w_state_nxt = MEM_PRI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MEM_PRI;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // A transfer to x0 is still accepted but never raises the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_rd   <= '0;
      write_data <= '0;
      wb_src     <= 1'b0;
    end else if (w_alu_gnt) begin
      reg_write  <= (alu_rd != 5'd0);
      write_rd   <= alu_rd;
      write_data <= alu_result;
      wb_src     <= 1'b0;
    end else if (w_mem_gnt) begin
      reg_write  <= (mem_rd != 5'd0);
      write_rd   <= mem_rd;
      write_data <= mem_data;
      wb_src     <= 1'b1;
    end else begin
      reg_write  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: reset, lone/simultaneous requests,
// starvation, x0 writes, stall hold and asynchronous reset mid-stream.
module tb_wb_port_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, mem_valid, stall;
  logic [4:0]      alu_rd, mem_rd;
  logic [XLEN-1:0] alu_result, mem_data;
  logic            alu_ready, mem_ready;
  logic            reg_write, wb_src;
  logic [4:0]      write_rd;
  logic [XLEN-1:0] write_data;

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .stall(stall),
    .reg_write(reg_write), .write_rd(write_rd), .write_data(write_data), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    alu_valid = v; alu_rd = rd; alu_result = d;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [63:0] d);
    mem_valid = v; mem_rd = rd; mem_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic rw, input logic [4:0] rd,
                        input logic [63:0] d, input logic src);
    chk({tag, ".reg_write"}, reg_write, rw);
    chk({tag, ".write_rd"}, write_rd, rd);
    chk({tag, ".write_data"}, write_data, d);
    chk({tag, ".wb_src"}, wb_src, src);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    set_alu(1'b1, 5'd1, 64'h11);
    set_mem(1'b1, 5'd2, 64'h22);
    #3;
    chk_wr("reset", 1'b0, 5'd0, 64'h0, 1'b0);
    chk("reset.alu_ready", alu_ready, 1'b0);
    chk("reset.mem_ready", mem_ready, 1'b0);
    set_alu(1'b0, 5'd0, 64'h0);
    set_mem(1'b0, 5'd0, 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();

    // lone ALU request
    set_alu(1'b1, 5'd5, 64'h1234);
    #1;
    chk("lone.alu_ready", alu_ready, 1'b1);
    chk("lone.mem_ready", mem_ready, 1'b0);
    step();
    chk_wr("lone", 1'b1, 5'd5, 64'h1234, 1'b0);
    set_alu(1'b0, 5'd0, 64'h0);
    step();
    chk_wr("idle_hold", 1'b0, 5'd5, 64'h1234, 1'b0);

    // simultaneous: memory first, then ALU
    set_alu(1'b1, 5'd3, 64'hA3);
    set_mem(1'b1, 5'd4, 64'hB4);
    #1;
    chk("both.mem_ready", mem_ready, 1'b1);
    chk("both.alu_ready", alu_ready, 1'b0);
    step();
    chk_wr("both.mem", 1'b1, 5'd4, 64'hB4, 1'b1);
    set_mem(1'b0, 5'd0, 64'h0);
    #1;
    chk("both2.alu_ready", alu_ready, 1'b1);
    step();
    chk_wr("both.alu", 1'b1, 5'd3, 64'hA3, 1'b0);
    set_alu(1'b0, 5'd0, 64'h0);
    step();

    // starvation: 3 mem grants, then the ALU once, then memory again
    set_alu(1'b1, 5'd7, 64'h77);
    for (int i = 0; i < 3; i++) begin
      set_mem(1'b1, 5'(10 + i), 64'(16'h100 + i));
      #1;
      chk($sformatf("starve%0d.mem_ready", i), mem_ready, 1'b1);
      chk($sformatf("starve%0d.alu_ready", i), alu_ready, 1'b0);
      step();
      chk_wr($sformatf("starve%0d", i), 1'b1, 5'(10 + i), 64'(16'h100 + i), 1'b1);
    end
    set_mem(1'b1, 5'd13, 64'h103);
    #1;
    chk("starve_win.alu_ready", alu_ready, 1'b1);
    chk("starve_win.mem_ready", mem_ready, 1'b0);
    step();
    chk_wr("starve_win", 1'b1, 5'd7, 64'h77, 1'b0);
    set_alu(1'b1, 5'd8, 64'h88);
    #1;
    chk("resume.mem_ready", mem_ready, 1'b1);
    chk("resume.alu_ready", alu_ready, 1'b0);
    step();
    chk_wr("resume", 1'b1, 5'd13, 64'h103, 1'b1);
    set_alu(1'b0, 5'd0, 64'h0);
    set_mem(1'b0, 5'd0, 64'h0);
    step();

    // write to x0 is accepted but suppressed
    set_mem(1'b1, 5'd0, 64'hDEAD);
    #1;
    chk("x0.mem_ready", mem_ready, 1'b1);
    step();
    chk("x0.reg_write", reg_write, 1'b0);
    chk("x0.wb_src", wb_src, 1'b1);
    set_mem(1'b0, 5'd0, 64'h0);
    step();

    // stall holds the starve count: 2 losses, stall 2 cycles, 1 loss, then ALU wins
    set_alu(1'b1, 5'd9, 64'h99);
    for (int i = 0; i < 2; i++) begin
      set_mem(1'b1, 5'(20 + i), 64'(16'h200 + i));
      step();
      chk_wr($sformatf("pre_stall%0d", i), 1'b1, 5'(20 + i), 64'(16'h200 + i), 1'b1);
    end
    set_mem(1'b1, 5'd22, 64'h222);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("stall%0d.alu_ready", i), alu_ready, 1'b0);
      chk($sformatf("stall%0d.mem_ready", i), mem_ready, 1'b0);
      step();
      chk_wr($sformatf("stall%0d", i), 1'b0, 5'd21, 64'h201, 1'b1);
    end
    stall = 1'b0;
    #1;
    chk("post_stall.mem_ready", mem_ready, 1'b1);
    chk("post_stall.alu_ready", alu_ready, 1'b0);
    step();
    chk_wr("post_stall", 1'b1, 5'd22, 64'h222, 1'b1);
    set_mem(1'b1, 5'd23, 64'h223);
    #1;
    chk("post_stall_win.alu_ready", alu_ready, 1'b1);
    chk("post_stall_win.mem_ready", mem_ready, 1'b0);
    step();
    chk_wr("post_stall_win", 1'b1, 5'd9, 64'h99, 1'b0);
    set_alu(1'b0, 5'd0, 64'h0);
    set_mem(1'b0, 5'd0, 64'h0);
    step();

    // drive into ALU_PRI, then reset asynchronously between edges
    set_alu(1'b1, 5'd11, 64'hBB);
    for (int i = 0; i < 3; i++) begin
      set_mem(1'b1, 5'(24 + i), 64'(16'h300 + i));
      step();
    end
    chk_wr("pre_reset", 1'b1, 5'd26, 64'h302, 1'b1);
    set_mem(1'b1, 5'd27, 64'h303);
    #1;
    chk("pre_reset.alu_ready", alu_ready, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_wr("async_reset", 1'b0, 5'd0, 64'h0, 1'b0);
    chk("async_reset.alu_ready", alu_ready, 1'b0);
    chk("async_reset.mem_ready", mem_ready, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("after_reset.mem_ready", mem_ready, 1'b1);
    chk("after_reset.alu_ready", alu_ready, 1'b0);
    step();
    chk_wr("after_reset", 1'b1, 5'd27, 64'h303, 1'b1);
    set_alu(1'b0, 5'd0, 64'h0);
    set_mem(1'b0, 5'd0, 64'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
